// File: rtl/comb_decim_combiner.sv
// Polyphase decimate-by-4 combiner: sums branches E1..E4 every fourth in_valid, rounds, reduces to OUT_W.
// Optional saturation via `COMB_DECIM_SAT_EN; otherwise the result wraps and sat_flag stays 0.
module comb_decim_combiner #(
    parameter int IN_W   = 17,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 2,
    parameter int WARMUP = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  e1_in,
    input  logic signed [IN_W-1:0]  e2_in,
    input  logic signed [IN_W-1:0]  e3_in,
    input  logic signed [IN_W-1:0]  e4_in,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    output logic                    overrun,
    output logic                    sat_flag
);

    localparam int SW = IN_W + 2;
    localparam int RW = SW + 1;
    localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);

    typedef enum logic {FILL, RUN} state_t;

    logic [1:0]              phase_q, phase_d;
    logic signed [SW-1:0]    sum_q, sum_d;
    logic                    sum_vld_q, sum_vld_d;
    logic signed [OUT_W-1:0] res_q, res_d;
    logic                    res_sat_q, res_sat_d;
    logic                    res_vld_q, res_vld_d;
    state_t                  state_q, state_d;
    logic [3:0]              warm_q, warm_d;
    logic signed [OUT_W-1:0] data_q, data_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic                    sat_q, sat_d;

    logic                    decim;
    logic                    present;
    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    shifted;

    // Stage 1: phase tracking and branch sum on the decimation beat.
    always_comb begin
        decim     = in_valid && (phase_q == 2'd3);
        phase_d   = in_valid ? phase_q + 2'd1 : phase_q;
        sum_vld_d = decim;
        sum_d     = sum_q;
        if (decim) begin
            sum_d = {{2{e1_in[IN_W-1]}}, e1_in} + {{2{e2_in[IN_W-1]}}, e2_in}
                  + {{2{e3_in[IN_W-1]}}, e3_in} + {{2{e4_in[IN_W-1]}}, e4_in};
        end
    end

    // Stage 2: round half up (one guard bit keeps the +HALF from overflowing), then reduce.
    always_comb begin
        rnd       = {sum_q[SW-1], sum_q} + HALF;
        shifted   = rnd >>> SHIFT;
        res_vld_d = sum_vld_q;
        res_d     = res_q;
        res_sat_d = res_sat_q;
        if (sum_vld_q) begin
`ifdef COMB_DECIM_SAT_EN
            if (shifted > RW'((1 << (OUT_W - 1)) - 1)) begin
                res_d     = {1'b0, {(OUT_W-1){1'b1}}};
                res_sat_d = 1'b1;
            end else if (shifted < RW'(-(1 << (OUT_W - 1)))) begin
                res_d     = {1'b1, {(OUT_W-1){1'b0}}};
                res_sat_d = 1'b1;
            end else begin
                res_d     = OUT_W'(shifted);
                res_sat_d = 1'b0;
            end
`else
            res_d     = OUT_W'(shifted);
            res_sat_d = 1'b0;
`endif
        end
    end

    // Warm-up FSM: discard the first WARMUP results, then present everything.
    always_comb begin
        state_d = state_q;
        warm_d  = warm_q;
        present = 1'b0;
        case (state_q)
            FILL: begin
                if (warm_q == '0) begin
                    state_d = RUN;
                    present = res_vld_q;
                end else if (res_vld_q) begin
                    warm_d = warm_q - 4'd1;
                    if (warm_q == 4'd1) state_d = RUN;
                end
            end
            RUN:     present = res_vld_q;
            default: state_d = FILL;
        endcase
    end

    // Output register: a load wins over a concurrent transfer.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        sat_d   = sat_q;
        if (present) begin
            data_d  = res_q;
            valid_d = 1'b1;
            if (valid_q && !out_ready) ovr_d = 1'b1;
            if (res_sat_q) sat_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= '0;
            sum_q     <= '0;
            sum_vld_q <= 1'b0;
            res_q     <= '0;
            res_sat_q <= 1'b0;
            res_vld_q <= 1'b0;
            state_q   <= FILL;
            warm_q    <= 4'(WARMUP);
            data_q    <= '0;
            valid_q   <= 1'b0;
            ovr_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            phase_q   <= phase_d;
            sum_q     <= sum_d;
            sum_vld_q <= sum_vld_d;
            res_q     <= res_d;
            res_sat_q <= res_sat_d;
            res_vld_q <= res_vld_d;
            state_q   <= state_d;
            warm_q    <= warm_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ovr_q     <= ovr_d;
            sat_q     <= sat_d;
        end
    end

    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign overrun   = ovr_q;
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_comb_decim_combiner.sv
// Scoreboard bench for comb_decim_combiner: stimulus side predicts results, monitor side checks outputs.
module tb_comb_decim_combiner;

    localparam int IN_W   = 17;
    localparam int OUT_W  = 16;
    localparam int SHIFT  = 2;
    localparam int WARMUP = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic signed [IN_W-1:0]  e1 = '0, e2 = '0, e3 = '0, e4 = '0;
    logic signed [OUT_W-1:0] out_data;
    logic out_valid, overrun, sat_flag;

    comb_decim_combiner #(.IN_W(IN_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .WARMUP(WARMUP)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .e1_in(e1), .e2_in(e2), .e3_in(e3), .e4_in(e4),
        .out_ready(out_ready), .out_data(out_data), .out_valid(out_valid),
        .overrun(overrun), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int val; int due; bit sat; } exp_t;
    exp_t q[$];

    int n_chk = 0;
    int n_pass = 0;
    int m_phase = 0;
    int m_warm = WARMUP;
    int rdy_mode = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
    endtask

    function automatic logic pick_rdy();
        if (rdy_mode == 0) return 1'b1;
        if (rdy_mode == 1) return 1'b0;
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference: every fourth beat yields round((a+b+c+d)/2^SHIFT) reduced to OUT_W bits.
    task automatic predict(input int a, input int b, input int c, input int d);
        exp_t e;
        int s, r;
        logic signed [OUT_W-1:0] w;
        s = a + b + c + d;
        r = (s + (1 << (SHIFT - 1))) >>> SHIFT;
        e.sat = 1'b0;
`ifdef COMB_DECIM_SAT_EN
        if (r > (1 << (OUT_W - 1)) - 1) begin r = (1 << (OUT_W - 1)) - 1; e.sat = 1'b1; end
        else if (r < -(1 << (OUT_W - 1))) begin r = -(1 << (OUT_W - 1)); e.sat = 1'b1; end
`else
        w = r[OUT_W-1:0];
        r = int'(w);
`endif
        e.val = r;
        e.due = cyc + 3;
        if (m_warm > 0) m_warm--;
        else q.push_back(e);
    endtask

    task automatic beat(input int a, input int b, input int c, input int d, input int gap);
        @(negedge clk);
        in_valid = 1'b1;
        e1 = IN_W'(a); e2 = IN_W'(b); e3 = IN_W'(c); e4 = IN_W'(d);
        out_ready = pick_rdy();
        if (m_phase == 3) predict(a, b, c, d);
        m_phase = (m_phase + 1) % 4;
        repeat (gap) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = pick_rdy();
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            out_ready = pick_rdy();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        q.delete();
        m_phase = 0;
        m_warm = WARMUP;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: tracks what the outputs must show after each edge.
    initial begin : monitor
        int exp_data;
        bit exp_valid, exp_ovr, exp_sat;
        exp_t e;
        exp_data = 0; exp_valid = 0; exp_ovr = 0; exp_sat = 0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                exp_data = 0; exp_valid = 0; exp_ovr = 0; exp_sat = 0;
                chk("rst_data", out_data, 0);
            end else begin
                while (q.size() > 0 && q[0].due < cyc) begin
                    e = q.pop_front();
                    chk("latency_missed", e.due, cyc);
                end
                if (q.size() > 0 && q[0].due == cyc) begin
                    e = q.pop_front();
                    if (exp_valid && !out_ready) exp_ovr = 1;
                    exp_valid = 1;
                    exp_data = e.val;
                    if (e.sat) exp_sat = 1;
                end else if (exp_valid && out_ready) begin
                    exp_valid = 0;
                end
                if (exp_valid) chk("out_data", out_data, exp_data);
            end
            chk("out_valid", out_valid, exp_valid);
            chk("overrun", overrun, exp_ovr);
            chk("sat_flag", sat_flag, exp_sat);
        end
    end

    initial begin : stimulus
        idle(3);
        rst = 1'b0;
        // Constant branches: first result discarded by warm-up, second is 250.
        rdy_mode = 0;
        repeat (8) beat(100, 200, 300, 400, 0);
        idle(6);
        // Backpressure across two results forces an overwrite.
        rdy_mode = 1;
        repeat (4) beat(1000, -3, 7, 2, 0);
        repeat (4) beat(-5000, 11, 13, -2, 1);
        idle(6);
        rdy_mode = 0;
        idle(4);
        // Extremes: saturation or wrap depending on build.
        repeat (4) beat(65535, 65535, 65535, 65535, 0);
        idle(5);
        repeat (4) beat(-65536, -65536, -65536, -65536, 0);
        idle(5);
        repeat (4) beat(1, 0, 0, 0, 0);
        repeat (4) beat(2, 0, 0, 0, 0);
        repeat (4) beat(-2, 0, 0, 0, 0);
        repeat (4) beat(-3, 0, 0, 0, 0);
        idle(5);
        // Reset mid-frame: two beats lost, warm-up restarts.
        repeat (2) beat(500, 500, 500, 500, 0);
        do_reset();
        repeat (8) beat(40, 41, 42, 43, 0);
        idle(5);
        // Randomised data, gaps and backpressure.
        for (int i = 0; i < 400; i++) begin
            rdy_mode = (i < 200) ? 2 : 0;
            beat(int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 131071)) - 65536, int'($urandom_range(0, 131071)) - 65536,
                 int'($urandom_range(0, 3)));
        end
        rdy_mode = 0;
        idle(10);
        chk("drain_empty", q.size(), 0);
        idle(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
